// File: rtl/matvec_pkg.sv
// Shared types for the matrix-vector stream controller.
// Sequencing state encoding and result-counter width.
package matvec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } matvec_state_t;

    localparam int MATVEC_CNT_W = 16;

endpackage

// File: rtl/mult_mat_vec_comb.sv
// Combinational unsigned matrix-vector product, each element truncated to 2*Nbits.
// Latency: none (pure combinational).
// Backpressure: none; the instantiating block sequences operands and captures results.
module mult_mat_vec_comb #(
    parameter int Mdata = 4,
    parameter int Ndata = 4,
    parameter int Nbits = 8
) (
    input  logic [Mdata*Ndata*Nbits-1:0] M,
    input  logic [Ndata*Nbits-1:0]       X,
    output logic [Mdata*2*Nbits-1:0]     out
);
    localparam int ROW_W = Ndata*Nbits;
    localparam int PW    = 2*Nbits;

    // Every product fits in PW bits; only the running sum wraps.
    function automatic logic [PW-1:0] dot(input logic [ROW_W-1:0] m_row,
                                          input logic [ROW_W-1:0] x_vec);
        logic [PW-1:0] acc;
        acc = '0;
        for (int j = 0; j < Ndata; j++) begin
            acc = acc + (PW'(m_row[j*Nbits +: Nbits]) * PW'(x_vec[j*Nbits +: Nbits]));
        end
        return acc;
    endfunction

    for (genvar r = 0; r < Mdata; r++) begin : g_row
        assign out[r*PW +: PW] = dot(M[r*ROW_W +: ROW_W], X);
    end

endmodule

// File: rtl/matvec_stream_ctrl.sv
// Loads an Mdata x Ndata matrix row by row, then streams vectors through mult_mat_vec_comb.
// Latency: 1 cycle from vector handshake to y_valid; one vector per cycle when y_ready is high.
// Backpressure: one-deep output register; x_ready drops while a result is stalled. MATVEC_CNT_EN adds vec_count.
module matvec_stream_ctrl
    import matvec_pkg::*;
#(
    parameter int Mdata = 4,
    parameter int Ndata = 4,
    parameter int Nbits = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [Ndata*Nbits-1:0]   ld_row,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [Ndata*Nbits-1:0]   x_data,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic [Mdata*2*Nbits-1:0] y_data,
    output logic                     mat_ok
`ifdef MATVEC_CNT_EN
    ,
    output logic [MATVEC_CNT_W-1:0]  vec_count
`endif
);
    localparam int ROW_W = Ndata*Nbits;
    localparam int MAT_W = Mdata*ROW_W;
    localparam int RC_W  = (Mdata > 1) ? $clog2(Mdata) : 1;
    localparam logic [RC_W-1:0] ROW_LAST = RC_W'(Mdata - 1);

    matvec_state_t               state, state_nxt;
    logic [RC_W-1:0]             row_cnt, row_nxt;
    logic [MAT_W-1:0]            mat_q;
    logic [Mdata*2*Nbits-1:0]    dp_out;
    logic                        ld_hs;
    logic                        x_hs;
    logic                        y_take;

    // Gating by rst_n keeps both ready outputs low for the whole reset window.
    assign ld_ready = rst_n && (state != RUN) && !clear;
    assign x_ready  = rst_n && (state == RUN) && !clear && (!y_valid || y_ready);
    assign ld_hs    = ld_valid && ld_ready;
    assign x_hs     = x_valid && x_ready;
    assign y_take   = y_valid && y_ready;
    assign mat_ok   = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            row_cnt <= '0;
        end else begin
            state   <= state_nxt;
            row_cnt <= row_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row_cnt;
        case (state)
            IDLE, LOAD: begin
                if (ld_hs) begin
                    if (row_cnt == ROW_LAST) begin
                        state_nxt = RUN;
                        row_nxt   = '0;
                    end else begin
                        state_nxt = LOAD;
                        row_nxt   = row_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (clear) begin
            state_nxt = IDLE;
            row_nxt   = '0;
        end
    end

    // clear leaves the coefficients in place; only reset zeroes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mat_q <= '0;
        end else if (ld_hs) begin
            for (int r = 0; r < Mdata; r++) begin
                if (row_cnt == RC_W'(r)) begin
                    mat_q[r*ROW_W +: ROW_W] <= ld_row;
                end
            end
        end
    end

    mult_mat_vec_comb #(
        .Mdata (Mdata),
        .Ndata (Ndata),
        .Nbits (Nbits)
    ) u_dp (
        .M   (mat_q),
        .X   (x_data),
        .out (dp_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
        end else if (clear) begin
            y_valid <= 1'b0;
        end else if (x_hs) begin
            y_valid <= 1'b1;
            y_data  <= dp_out;
        end else if (y_take) begin
            y_valid <= 1'b0;
        end
    end

`ifdef MATVEC_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            vec_count <= '0;
        end else if (y_take) begin
            vec_count <= vec_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_matvec_stream_ctrl.sv
// Randomized bench for matvec_stream_ctrl against a plain-arithmetic reference model.
// Builds with or without MATVEC_CNT_EN.
module tb_matvec_stream_ctrl;
    localparam int MD = 4;
    localparam int ND = 4;
    localparam int NB = 8;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_row;
    logic        x_valid;
    logic        x_ready;
    logic [31:0] x_data;
    logic        y_valid;
    logic        y_ready;
    logic [63:0] y_data;
    logic        mat_ok;
`ifdef MATVEC_CNT_EN
    logic [15:0] vec_count;
`endif

    matvec_stream_ctrl #(
        .Mdata (MD),
        .Ndata (ND),
        .Nbits (NB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_row   (ld_row),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .x_data   (x_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_data   (y_data),
        .mat_ok   (mat_ok)
`ifdef MATVEC_CNT_EN
        ,
        .vec_count(vec_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: rows loaded so far, coefficient table, pending result, consume count.
    int          m_rows;
    int unsigned m_mat [MD][ND];
    bit          m_yv;
    int unsigned m_y   [MD];
    int unsigned m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_y();
        logic [63:0] v;
        v = '0;
        for (int r = 0; r < MD; r++) v[r*16 +: 16] = m_y[r][15:0];
        return v;
    endfunction

    task automatic model_reset();
        m_rows = 0;
        m_yv   = 0;
        m_cnt  = 0;
        for (int r = 0; r < MD; r++) begin
            m_y[r] = 0;
            for (int j = 0; j < ND; j++) m_mat[r][j] = 0;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check, then advance the model across the rising edge.
    task automatic step(input logic lv, input logic [31:0] row, input logic xv,
                        input logic [31:0] xd, input logic yr, input logic clr);
        bit e_ldr, e_xr, lhs, xhs, take;
        int unsigned sum;
        ld_valid = lv; ld_row = row; x_valid = xv; x_data = xd; y_ready = yr; clear = clr;
        #1;
        e_ldr = rst_n && (m_rows < MD) && !clr;
        e_xr  = rst_n && (m_rows == MD) && !clr && (!m_yv || yr);
        check_eq("ld_ready", ld_ready, e_ldr);
        check_eq("x_ready", x_ready, e_xr);
        if (rst_n) begin
            check_eq("y_valid", y_valid, m_yv);
            check_eq("mat_ok", mat_ok, m_rows == MD);
            if (m_yv) check_eq("y_data", y_data, model_y());
`ifdef MATVEC_CNT_EN
            check_eq("vec_count", vec_count, m_cnt & 32'hFFFF);
`endif
        end
        lhs  = lv && e_ldr;
        xhs  = xv && e_xr;
        take = m_yv && yr;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (clr) begin
            m_rows = 0;
            m_yv   = 0;
            m_cnt  = 0;
        end else begin
            if (lhs) begin
                for (int j = 0; j < ND; j++) m_mat[m_rows][j] = row[j*8 +: 8];
                m_rows++;
            end
            if (xhs) begin
                for (int r = 0; r < MD; r++) begin
                    sum = 0;
                    for (int j = 0; j < ND; j++) sum += m_mat[r][j] * xd[j*8 +: 8];
                    m_y[r] = sum % 65536;
                end
                m_yv = 1;
            end else if (take) begin
                m_yv = 0;
            end
            if (take) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic idle_step(input logic yr);
        step(1'b0, 32'h0, 1'b0, 32'h0, yr, 1'b0);
    endtask

    task automatic load_row(input logic [31:0] row);
        step(1'b1, row, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic random_stream(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step($urandom_range(3, 0) != 0, $urandom, $urandom_range(3, 0) != 0,
                 $urandom, $urandom_range(2, 0) != 0, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; ld_valid = 1'b0; ld_row = '0;
        x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
        model_reset();

        // Reset held three edges; DUT state is unknown before the first edge.
        @(posedge clk);
        @(negedge clk);
        step(1'b1, 32'h1234_5678, 1'b1, 32'h1, 1'b1, 1'b0);
        step(1'b1, 32'h1234_5678, 1'b1, 32'h1, 1'b1, 1'b0);
        check_eq("rst_y_valid", y_valid, 1'b0);
        check_eq("rst_y_data", y_data, 64'h0);
        check_eq("rst_mat_ok", mat_ok, 1'b0);
        rst_n = 1'b1;

        // Basic result from the reference table.
        load_row(32'h0506_0701);
        load_row(32'h0403_0201);
        idle_step(1'b1);
        load_row(32'h0405_0000);
        load_row(32'h0103_0502);
        step(1'b0, 32'h0, 1'b1, 32'h0102_0101, 1'b0, 1'b0);
        #1;
        check_eq("basic_valid", y_valid, 1'b1);
        check_eq("basic_data", y_data, 64'h000E_000E_000D_0019);
        idle_step(1'b1);

        // Backpressure: accept one, stall three cycles with x_valid held, then stream.
        step(1'b0, 32'h0, 1'b1, 32'h0A0B_0C0D, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 32'h1111_2222, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, $urandom, 1'b1, 1'b0);
        idle_step(1'b1);

        random_stream(300);

        // Overflow wrap with all-ones operands.
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < MD; i++) load_row(32'hFFFF_FFFF);
        step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        #1;
        check_eq("wrap_data", y_data, 64'hF804_F804_F804_F804);
        idle_step(1'b1);

        // Clear mid-load, with ld_valid asserted during clear, then a fresh load.
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        load_row($urandom);
        load_row($urandom);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        check_eq("midload_mat_ok", mat_ok, 1'b0);
        for (int i = 0; i < MD; i++) load_row($urandom);
        random_stream(200);

        // Clear with a stalled result and x_valid high.
        idle_step(1'b1);
        step(1'b0, 32'h0, 1'b1, $urandom, 1'b1, 1'b0);
        idle_step(1'b0);
        step(1'b0, 32'h0, 1'b1, $urandom, 1'b1, 1'b1);
        #1;
        check_eq("clr_y_valid", y_valid, 1'b0);
        check_eq("clr_mat_ok", mat_ok, 1'b0);
`ifdef MATVEC_CNT_EN
        check_eq("clr_vec_count", vec_count, 16'h0);
`endif

        // Reset mid-load abandons the partial matrix.
        for (int i = 0; i < MD; i++) load_row($urandom);
        random_stream(50);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        load_row($urandom);
        load_row($urandom);
        rst_n = 1'b0;
        step(1'b1, $urandom, 1'b0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < MD; i++) load_row($urandom);
        random_stream(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/matvec_stream_ctrl.md
# matvec_stream_ctrl

Sequencing controller for the combinational matrix-vector datapath `mult_mat_vec_comb`. The block loads an Mdata×Ndata coefficient matrix row by row and holds it. It then streams input vectors through the datapath under valid/ready handshakes. Each result is registered into a one-deep output stage with backpressure. It sits between the host-side load/stream interfaces and downstream result consumers.

## Interface
- `Mdata`, 4, matrix rows = output vector elements
- `Ndata`, 4, matrix columns = input vector elements
- `Nbits`, 8, unsigned element width; result elements are 2*Nbits
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `clear`  in  1  drop the matrix, flush the output stage, return to IDLE
- `ld_valid`  in  1  matrix row valid
- `ld_ready`  out  1  matrix row accepted
- `ld_row`  in  Ndata*Nbits  matrix row; element j at `[j*Nbits +: Nbits]`
- `x_valid`  in  1  input vector valid
- `x_ready`  out  1  input vector accepted
- `x_data`  in  Ndata*Nbits  vector; element j at `[j*Nbits +: Nbits]`
- `y_valid`  out  1  result valid
- `y_ready`  in  1  result consumed
- `y_data`  out  Mdata*2*Nbits  result; element r at `[r*2*Nbits +: 2*Nbits]`
- `mat_ok`  out  1  full matrix loaded (state RUN)

## Operation
- States: IDLE, LOAD, RUN.
  - IDLE → LOAD on the first row handshake.
  - LOAD → RUN on the Mdata-th row handshake.
  - RUN persists until `clear` or reset.
- Row handshake is `ld_valid && ld_ready`.
  - Row r is stored in the matrix register at `[r*Ndata*Nbits +: Ndata*Nbits]`.
  - Rows are loaded in order, row 0 first.
  - Row counter width is `$clog2(Mdata)`, minimum 1. It resets to 0 on entering IDLE.
- `ld_ready` = (state != RUN) && !`clear`.
- `x_ready` = (state == RUN) && !`clear` && (!`y_valid` || `y_ready`).
- On a vector handshake:
  - `y_data` <= datapath output.
  - `y_valid` <= 1.
- On a result consumed (`y_valid && y_ready`) with no new vector handshake in the same cycle, `y_valid` <= 0.
- Arithmetic: unsigned. Each element is y[r] = Σ_j M[r][j]*x[j] modulo 2^(2*Nbits). The datapath truncates; the block adds no saturation.
- `clear` has priority over everything:
  - Next state is IDLE; row counter and `y_valid` go to 0.
  - A pending result is discarded.
  - The matrix register is not zeroed.
- `x_valid` in IDLE/LOAD is ignored (`x_ready` = 0). `ld_valid` in RUN is ignored (`ld_ready` = 0).
- To reload the matrix, assert `clear` for one cycle, then load Mdata rows.

## Timing
- Reset (`rst_n` = 0 at an edge) sets:
  - State IDLE, row counter 0.
  - `y_valid` = 0, `y_data` = 0, `mat_ok` = 0, matrix register = 0.
- While `rst_n` is low, `ld_ready` = `x_ready` = 0.
- Matrix load takes exactly Mdata handshake cycles. `mat_ok` rises the cycle after the last row edge.
- Vector latency: 1 cycle, i.e. handshake at edge N gives `y_valid` = 1 after edge N.
- Throughput: one vector per cycle while `y_ready` = 1.
- Backpressure:
  - With `y_valid` = 1 and `y_ready` = 0: `x_ready` = 0, and `y_data` is held stable.
- Simultaneous consume and accept in the same cycle: `y_valid` stays 1 and `y_data` updates.
- Reset or `clear` mid-load: partial rows are abandoned; the next load starts at row 0.

## Configuration
- `MATVEC_CNT_EN` defined:
  - Adds output `vec_count` (16 bits), the number of results consumed since entering RUN.
  - Wraps at 2^16. Cleared by reset and by `clear`.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `matvec_pkg`:
  - State enum `matvec_state_t` {IDLE, LOAD, RUN}.
  - Counter width constant `MATVEC_CNT_W` = 16.
- One sub-module: `mult_mat_vec_comb` (ports `M`, `X`, `out`).
  - `M` is driven from the matrix register.
  - `X` is driven from `x_data`.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles → all outputs 0, state IDLE; `ld_ready` = 1 on the first cycle after release.
- **Basic result:** load rows {5,6,7,1}, {4,3,2,1}, {4,5,0,0}, {1,3,5,2} (listed MSB-first), then X = {1,2,1,1} MSB-first → `y_data` elements r3..r0 = {14,14,13,25}, `y_valid` one cycle after the handshake.
- **Overflow wrap:** all matrix elements and all x elements = 255 → every result element = 63492 (260100 mod 65536).
- **Backpressure:** stream 4 vectors with `y_ready` low for 3 cycles → `x_ready` = 0 while stalled, `y_data` stable, no result lost or duplicated.
- **Clear mid-load:** `clear` after 2 rows → state IDLE, `mat_ok` stays 0; a fresh 4-row load then produces correct results.
- **Clear with a pending result and simultaneous `x_valid`:** no handshake occurs, `y_valid` = 0 next cycle; with `MATVEC_CNT_EN` defined, `vec_count` = 0.
